// File: rtl/alt_vipcti121_common_sample_assembler_pkg.sv
// Shared sizing for the receive-side sample assembler: default geometry,
// derived widths and the colour-plane transport mode.
package alt_vipcti121_common_sample_assembler_pkg;

  localparam int DEF_BITS_PER_SYMBOL              = 8;
  localparam int DEF_NUMBER_OF_COLOUR_PLANES      = 3;
  localparam int DEF_LOG2_NUMBER_OF_COLOUR_PLANES = 2;
  localparam int DEF_SAMPLE_W = DEF_BITS_PER_SYMBOL * DEF_NUMBER_OF_COLOUR_PLANES;

  typedef enum logic {
    MODE_SEQ = 1'b0,
    MODE_PAR = 1'b1
  } mode_e;

  function automatic int sample_width(input int bps, input int ncp);
    return bps * ncp;
  endfunction

  // Accumulator holds every plane but the last; keep one plane for NCP==1 so
  // the vector never collapses to zero width.
  function automatic int acc_width(input int bps, input int ncp);
    return (ncp > 1) ? bps * (ncp - 1) : bps;
  endfunction

  function automatic bit multi_plane(input int ncp);
    return ncp > 1;
  endfunction

endpackage

// File: rtl/alt_vipcti121_common_sample_assembler_if.sv
// Valid/ready stream carrying one colour-plane beat or one assembled sample.
interface alt_vipcti121_common_sample_assembler_if
  import alt_vipcti121_common_sample_assembler_pkg::*;
#(
  parameter int DATA_W = DEF_SAMPLE_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/alt_vipcti121_common_plane_counter.sv
// Modulo-NCP colour-plane counter with sync clear, clear-and-load-1 and wrap flag.
module alt_vipcti121_common_plane_counter
  import alt_vipcti121_common_sample_assembler_pkg::*;
#(
  parameter int NCP = DEF_NUMBER_OF_COLOUR_PLANES,
  parameter int L   = DEF_LOG2_NUMBER_OF_COLOUR_PLANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sclr,
  input  logic         par,
  input  logic         inc,
  output logic [L-1:0] count,
  output logic         wrap
);

  generate
    if (NCP > 1) begin : g_cnt
      localparam logic [L-1:0] LAST = L'(NCP - 1);

      // Parallel transport owns no partial sample, so it pins the count at 0;
      // a realign that coincides with a beat makes that beat plane 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (par) begin
          count <= '0;
        end else if (sclr) begin
          count <= inc ? L'(1) : '0;
        end else if (inc) begin
          count <= wrap ? '0 : count + 1'b1;
        end
      end

      assign wrap = (count == LAST);
    end else begin : g_one
      assign count = '0;
      assign wrap  = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/alt_vipcti121_common_sample_assembler.sv
// Assembles colour-plane beats (sequential or parallel) into full pixel samples
// behind a single registered output slot with valid/ready backpressure.
module alt_vipcti121_common_sample_assembler
  import alt_vipcti121_common_sample_assembler_pkg::*;
#(
  parameter int BITS_PER_SYMBOL              = DEF_BITS_PER_SYMBOL,
  parameter int NUMBER_OF_COLOUR_PLANES      = DEF_NUMBER_OF_COLOUR_PLANES,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES = DEF_LOG2_NUMBER_OF_COLOUR_PLANES
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    sclr,
  input  logic                                    hd_sdn,
  alt_vipcti121_common_sample_assembler_if.slave  din_if,
  alt_vipcti121_common_sample_assembler_if.master dout_if,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_index
);

  localparam int BPS      = BITS_PER_SYMBOL;
  localparam int NCP      = NUMBER_OF_COLOUR_PLANES;
  localparam int L        = LOG2_NUMBER_OF_COLOUR_PLANES;
  localparam int SAMPLE_W = sample_width(BPS, NCP);
  localparam int ACC_W    = acc_width(BPS, NCP);
  localparam bit MULTI    = multi_plane(NCP);

  mode_e               mode;
  logic                seq_mode;
  logic                accept;
  logic                pop;
  logic                complete;
  logic                wrap;
  logic [L-1:0]        count_p0;
  logic [L-1:0]        wr_plane;
  logic [ACC_W-1:0]    acc_p0;
  logic [SAMPLE_W-1:0] sample_p0;
  logic [SAMPLE_W-1:0] dout_p1;
  logic                vld_p1;

  assign mode     = mode_e'(hd_sdn);
  assign seq_mode = MULTI && (mode == MODE_SEQ);

  // Non-final planes only land in the accumulator, so they never wait on the slot.
  assign din_if.ready = ~vld_p1 | dout_if.ready | (seq_mode & ~wrap);
  assign accept       = din_if.valid & din_if.ready;
  assign pop          = vld_p1 & dout_if.ready;
  assign complete     = accept & (~seq_mode | (wrap & ~sclr));
  assign wr_plane     = sclr ? '0 : count_p0;

  alt_vipcti121_common_plane_counter #(
    .NCP (NCP),
    .L   (L)
  ) u_plane_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .sclr  (sclr),
    .par   (~seq_mode),
    .inc   (accept),
    .count (count_p0),
    .wrap  (wrap)
  );

  // ---- stage p0: partial-sample accumulator ----
  generate
    if (MULTI) begin : g_acc
      logic [ACC_W-1:0] acc_nxt;

      always_comb begin
        acc_nxt = sclr ? '0 : acc_p0;
        if (seq_mode && accept && !complete) begin
          acc_nxt[wr_plane*BPS +: BPS] = din_if.data[BPS-1:0];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_p0 <= '0;
        end else begin
          acc_p0 <= acc_nxt;
        end
      end

      // The final plane bypasses the accumulator and sits in the top slot.
      assign sample_p0 = seq_mode ? {din_if.data[BPS-1:0], acc_p0} : din_if.data;
    end else begin : g_single
      assign acc_p0    = '0;
      assign sample_p0 = din_if.data;
    end
  endgenerate

  // ---- stage p1: output slot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else if (complete) begin
      vld_p1  <= 1'b1;
      dout_p1 <= sample_p0;
    end else if (pop) begin
      vld_p1  <= 1'b0;
    end
  end

  assign dout_if.valid = vld_p1;
  assign dout_if.data  = dout_p1;
  assign plane_index   = count_p0;

endmodule

// File: tb/tb_alt_vipcti121_common_sample_assembler.sv
// Directed bench for the sample assembler with a queue-based reference model.
module tb_alt_vipcti121_common_sample_assembler;
  import alt_vipcti121_common_sample_assembler_pkg::*;

  localparam int BPS = DEF_BITS_PER_SYMBOL;
  localparam int NCP = DEF_NUMBER_OF_COLOUR_PLANES;
  localparam int L   = DEF_LOG2_NUMBER_OF_COLOUR_PLANES;
  localparam int SW  = BPS * NCP;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         sclr   = 1'b0;
  logic         hd_sdn = 1'b0;
  logic [L-1:0] plane_index;

  alt_vipcti121_common_sample_assembler_if #(.DATA_W(SW)) din_if ();
  alt_vipcti121_common_sample_assembler_if #(.DATA_W(SW)) dout_if ();

  alt_vipcti121_common_sample_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclr        (sclr),
    .hd_sdn      (hd_sdn),
    .din_if      (din_if),
    .dout_if     (dout_if),
    .plane_index (plane_index)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: planes collected so far, plus the one-deep output slot.
  logic [BPS-1:0] part[$];
  logic           m_vld  = 1'b0;
  logic [SW-1:0]  m_dout = '0;
  logic [SW-1:0]  m_smp  = '0;
  logic           m_acc  = 1'b0;
  logic           m_pop  = 1'b0;
  logic           m_done = 1'b0;

  function automatic logic m_ready();
    return !m_vld || dout_if.ready || (!hd_sdn && part.size() != NCP - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part.delete();
      m_vld  = 1'b0;
      m_dout = '0;
    end else begin
      m_acc  = din_if.valid && m_ready();
      m_pop  = m_vld && dout_if.ready;
      m_done = 1'b0;
      if (sclr || hd_sdn) part.delete();
      if (m_acc) begin
        if (hd_sdn) begin
          m_smp  = din_if.data;
          m_done = 1'b1;
        end else begin
          part.push_back(din_if.data[BPS-1:0]);
          if (part.size() == NCP) begin
            m_smp = '0;
            foreach (part[i]) m_smp = m_smp | (SW'(part[i]) << (BPS * i));
            part.delete();
            m_done = 1'b1;
          end
        end
      end
      if (m_done) begin
        m_vld  = 1'b1;
        m_dout = m_smp;
      end else if (m_pop) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("dout_valid", 32'(dout_if.valid), 32'(m_vld));
    if (m_vld) chk("dout", 32'(dout_if.data), 32'(m_dout));
    chk("plane_index", 32'(plane_index), 32'(part.size()));
    chk("din_ready", 32'(din_if.ready), 32'(m_ready()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_if.valid = 1'b0;
    repeat (n) step();
  endtask

  // Presents a beat until accepted; leaves valid high so beats can stream.
  task automatic send(input logic [SW-1:0] d);
    bit ok;
    ok = 1'b0;
    din_if.valid = 1'b1;
    din_if.data  = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      ok = din_if.ready;
      step();
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: beat %0h not accepted within 20 cycles", d);
    end
  endtask

  initial begin
    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;
    repeat (3) step();
    chk("rst_dout_valid", 32'(dout_if.valid), 32'd0);
    chk("rst_dout", 32'(dout_if.data), 32'd0);
    chk("rst_plane_index", 32'(plane_index), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_din_ready", 32'(din_if.ready), 32'd1);

    // Basic sequential assembly
    dout_if.ready = 1'b1;
    send(24'h11); chk("seq_pidx1", 32'(plane_index), 32'd1);
    send(24'h22); chk("seq_pidx2", 32'(plane_index), 32'd2);
    send(24'h33);
    din_if.valid = 1'b0;
    chk("seq_valid", 32'(dout_if.valid), 32'd1);
    chk("seq_dout", 32'(dout_if.data), 32'h332211);
    chk("seq_pidx0", 32'(plane_index), 32'd0);
    idle(1);
    chk("seq_popped", 32'(dout_if.valid), 32'd0);

    // Backpressure: slot full, two more planes accepted, final plane stalls
    dout_if.ready = 1'b0;
    send(24'hAA); send(24'hBB); send(24'hCC);
    din_if.valid = 1'b0;
    chk("bp_first", 32'(dout_if.data), 32'hCCBBAA);
    send(24'hDD); send(24'hEE);
    din_if.data = 24'hFF;
    repeat (3) step();
    chk("bp_stall_ready", 32'(din_if.ready), 32'd0);
    chk("bp_hold_dout", 32'(dout_if.data), 32'hCCBBAA);
    chk("bp_hold_pidx", 32'(plane_index), 32'd2);
    dout_if.ready = 1'b1;
    step();
    din_if.valid = 1'b0;
    chk("bp_reload_valid", 32'(dout_if.valid), 32'd1);
    chk("bp_reload_dout", 32'(dout_if.data), 32'hFFEEDD);
    idle(1);
    chk("bp_drained", 32'(dout_if.valid), 32'd0);

    // Back-to-back samples with continuous valid
    for (int i = 1; i <= 9; i++) send(SW'(i));
    din_if.valid = 1'b0;
    chk("b2b_last", 32'(dout_if.data), 32'h090807);
    idle(1);

    // Realign: partial discarded, the sclr beat becomes plane 0
    send(24'h77); send(24'h88);
    din_if.valid = 1'b0;
    chk("sclr_pre_pidx", 32'(plane_index), 32'd2);
    sclr = 1'b1;
    send(24'h44);
    sclr = 1'b0;
    din_if.valid = 1'b0;
    chk("sclr_pidx", 32'(plane_index), 32'd1);
    send(24'h55); send(24'h66);
    din_if.valid = 1'b0;
    chk("sclr_dout", 32'(dout_if.data), 32'h665544);
    idle(1);

    // Mid-sample mode change abandons the partial sample
    send(24'h12); send(24'h13);
    din_if.valid = 1'b0;
    hd_sdn = 1'b1;
    step();
    hd_sdn = 1'b0;
    step();
    chk("mode_abandon_pidx", 32'(plane_index), 32'd0);
    send(24'h21); send(24'h22); send(24'h23);
    din_if.valid = 1'b0;
    chk("mode_abandon_dout", 32'(dout_if.data), 32'h232221);
    idle(1);

    // Parallel mode: one sample per clock
    hd_sdn = 1'b1;
    for (int i = 0; i < 4; i++) send(24'hABCDEF);
    din_if.valid = 1'b0;
    chk("par_dout", 32'(dout_if.data), 32'hABCDEF);
    chk("par_valid", 32'(dout_if.valid), 32'd1);
    chk("par_pidx", 32'(plane_index), 32'd0);
    idle(1);
    hd_sdn = 1'b0;

    // Async reset with a pending sample and a partial one
    dout_if.ready = 1'b0;
    send(24'h01); send(24'h02); send(24'h03); send(24'h04); send(24'h05);
    din_if.valid = 1'b0;
    chk("pre_rst_pidx", 32'(plane_index), 32'd2);
    chk("pre_rst_valid", 32'(dout_if.valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(dout_if.valid), 32'd0);
    chk("async_rst_dout", 32'(dout_if.data), 32'd0);
    chk("async_rst_pidx", 32'(plane_index), 32'd0);
    step();
    rst_n = 1'b1;
    dout_if.ready = 1'b1;
    send(24'h31); send(24'h32); send(24'h33);
    din_if.valid = 1'b0;
    chk("post_rst_dout", 32'(dout_if.data), 32'h333231);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
